// File: rtl/override_arbiter.sv
// Round-robin override arbiter owning a register whose field can be taken over by one
// requester at a time, with an optional hold timeout and a mandatory idle cycle after release.
module override_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 32,
    parameter int FIELD_LSB = 0,
    parameter int FIELD_W   = 4,
    parameter int MAX_HOLD  = 0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      bg_valid,
    input  logic [WIDTH-1:0]          bg_data,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*FIELD_W-1:0]   req_data,
    output logic [NREQ-1:0]           grant,
    output logic                      override_active,
    output logic                      timeout,
    output logic [WIDTH-1:0]          value
);

    localparam int PTR_W      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int CNT_LAST_I = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : ((1 << CNT_W) - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_LAST_I[CNT_W-1:0];
    localparam logic [WIDTH-1:0] FIELD_MASK = ((WIDTH'(1) << FIELD_W) - WIDTH'(1)) << FIELD_LSB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic [CNT_W-1:0]   hold_cnt;
    logic [NREQ-1:0]    blocked;

    logic [NREQ-1:0]    eligible;
    logic               found;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   winner_next;
    logic               owner_req;
    logic [FIELD_W-1:0] owner_data;
    logic               hold_done;
    logic [WIDTH-1:0]   bg_next;
    logic [WIDTH-1:0]   field_next;
    logic [WIDTH-1:0]   value_next;

    assign eligible = req & ~blocked;

    // Round-robin scan upward from ptr, wrapping at NREQ-1.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && eligible[(int'(ptr) + k) % NREQ]) begin
                found  = 1'b1;
                winner = PTR_W'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign winner_next = (winner == PTR_W'(NREQ - 1)) ? '0 : winner + PTR_W'(1);

    always_comb begin
        owner_req  = 1'b0;
        owner_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == PTR_W'(i)) begin
                owner_req  = req[i];
                owner_data = req_data[i*FIELD_W +: FIELD_W];
            end
        end
    end

    assign hold_done = (MAX_HOLD != 0) && (hold_cnt == CNT_LAST);

    // The field is frozen on the voluntary-release edge so the last override value survives.
    always_comb begin
        bg_next    = bg_valid ? bg_data : value;
        field_next = bg_next;
        if (state == HOLD) begin
            field_next = owner_req ? (WIDTH'(owner_data) << FIELD_LSB) : value;
        end
        value_next = (bg_next & ~FIELD_MASK) | (field_next & FIELD_MASK);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state           <= IDLE;
            ptr             <= '0;
            owner           <= '0;
            hold_cnt        <= '0;
            blocked         <= '0;
            grant           <= '0;
            override_active <= 1'b0;
            timeout         <= 1'b0;
            value           <= '0;
        end else begin
            value   <= value_next;
            timeout <= 1'b0;
            blocked <= blocked & req;
            case (state)
                IDLE: begin
                    if (found) begin
                        state           <= HOLD;
                        owner           <= winner;
                        ptr             <= winner_next;
                        hold_cnt        <= '0;
                        grant           <= NREQ'(1) << winner;
                        override_active <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!owner_req) begin
                        state           <= GAP;
                        grant           <= '0;
                        override_active <= 1'b0;
                    end else if (hold_done) begin
                        // Forced release: owner must drop its request before it can win again.
                        state           <= GAP;
                        grant           <= '0;
                        override_active <= 1'b0;
                        timeout         <= 1'b1;
                        blocked[owner]  <= 1'b1;
                    end else if (hold_cnt != CNT_LAST) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state           <= IDLE;
                    grant           <= '0;
                    override_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_override_arbiter.sv
// Directed and randomized bench for override_arbiter, compared each cycle against a
// behavioural model of owner, release gap, timeout blocking and field ownership.
module tb_override_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 32;
    localparam int FIELD_W  = 4;
    localparam int MAX_HOLD = 5;

    logic                    clock;
    logic                    reset_n;
    logic                    bg_valid;
    logic [WIDTH-1:0]        bg_data;
    logic [NREQ-1:0]         req;
    logic [NREQ*FIELD_W-1:0] req_data;
    logic [NREQ-1:0]         grant;
    logic                    override_active;
    logic                    timeout;
    logic [WIDTH-1:0]        value;

    int checks   = 0;
    int failures = 0;

    // Model state: owner index (-1 when none), gap flag, grant cycles so far.
    int          mOwner = -1;
    int          mPtr   = 0;
    int          mHold  = 0;
    bit          mGap   = 1'b0;
    bit [3:0]    mBlocked = '0;
    bit          mTimeout = 1'b0;
    logic [31:0] mValue = '0;

    override_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .FIELD_LSB(0), .FIELD_W(FIELD_W), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bg_valid(bg_valid),
        .bg_data(bg_data),
        .req(req),
        .req_data(req_data),
        .grant(grant),
        .override_active(override_active),
        .timeout(timeout),
        .value(value)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rn, input logic bv, input logic [31:0] bd,
                                 input logic [3:0] rq, input logic [15:0] rd);
        reset_n  = rn;
        bg_valid = bv;
        bg_data  = bd;
        req      = rq;
        req_data = rd;
    endtask

    task automatic modelEdge();
        logic [31:0] nb;
        logic [3:0]  fld;
        int          cand;
        if (!reset_n) begin
            mOwner = -1; mPtr = 0; mHold = 0; mGap = 1'b0;
            mBlocked = '0; mTimeout = 1'b0; mValue = '0;
            return;
        end
        nb = bg_valid ? bg_data : mValue;
        if (mOwner >= 0) fld = req[mOwner] ? req_data[mOwner*4 +: 4] : mValue[3:0];
        else             fld = nb[3:0];
        mValue   = {nb[31:4], fld};
        mTimeout = 1'b0;
        for (int i = 0; i < 4; i++) if (!req[i]) mBlocked[i] = 1'b0;
        if (mOwner >= 0) begin
            if (!req[mOwner]) begin
                mOwner = -1; mGap = 1'b1;
            end else if (mHold == MAX_HOLD) begin
                mBlocked[mOwner] = 1'b1; mTimeout = 1'b1; mOwner = -1; mGap = 1'b1;
            end else begin
                mHold++;
            end
        end else if (mGap) begin
            mGap = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                cand = (mPtr + k) % 4;
                if (mOwner < 0 && req[cand] && !mBlocked[cand]) begin
                    mOwner = cand; mPtr = (cand + 1) % 4; mHold = 1;
                end
            end
        end
    endtask

    task automatic tick();
        logic [31:0] expGrant;
        @(posedge clock);
        modelEdge();
        #1;
        expGrant = (mOwner >= 0) ? (32'd1 << mOwner) : 32'd0;
        checkOutput("grant", 32'(grant), expGrant);
        checkOutput("override_active", 32'(override_active), 32'(mOwner >= 0));
        checkOutput("timeout", 32'(timeout), 32'(mTimeout));
        checkOutput("value", value, mValue);
    endtask

    initial begin
        int order[4];
        order[0] = 0; order[1] = 1; order[2] = 3; order[3] = 0;

        applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 16'h0000);
        tick(); tick();
        checkOutput("reset_value", value, 32'h0);
        checkOutput("reset_grant", 32'(grant), 32'h0);

        // Background writes only.
        applyStimulus(1'b1, 1'b1, 32'h3, 4'b0000, 16'h0000);
        repeat (3) tick();
        checkOutput("bg_value", value, 32'h3);
        checkOutput("bg_active", 32'(override_active), 32'h0);

        // Override by requester 1, then release and persistence.
        applyStimulus(1'b1, 1'b1, 32'h3, 4'b0010, 16'h0020);
        tick();
        checkOutput("ovr_grant", 32'(grant), 32'h2);
        checkOutput("ovr_entry_field", value, 32'h3);
        tick();
        checkOutput("ovr_field", value, 32'h2);
        tick();
        checkOutput("ovr_track", value, 32'h2);
        applyStimulus(1'b1, 1'b0, 32'h3, 4'b0000, 16'h0020);
        tick();
        checkOutput("rel_grant", 32'(grant), 32'h0);
        checkOutput("rel_value", value, 32'h2);
        repeat (2) tick();
        checkOutput("rel_persist", value, 32'h2);
        applyStimulus(1'b1, 1'b1, 32'h3, 4'b0000, 16'h0000);
        tick();
        checkOutput("rel_bg", value, 32'h3);

        // Round robin after reset: order 0,1,3,0 with one gap cycle.
        applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 16'h0000);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 4'b1011, 16'h4321);
        tick();
        for (int j = 0; j < 4; j++) begin
            checkOutput("rr_grant", 32'(grant), 32'd1 << order[j]);
            tick();
            checkOutput("rr_hold", 32'(grant), 32'd1 << order[j]);
            req = 4'b1011 & ~(4'd1 << order[j]);
            tick();
            checkOutput("rr_release", 32'(grant), 32'h0);
            req = 4'b1011;
            tick();
            checkOutput("rr_gap", 32'(grant), 32'h0);
            tick();
        end
        req = 4'b0000;
        repeat (3) tick();

        // Timeout after MAX_HOLD grant cycles, then blocking until req drops.
        applyStimulus(1'b1, 1'b0, 32'h0, 4'b0100, 16'h0700);
        tick();
        checkOutput("to_grant", 32'(grant), 32'h4);
        for (int k = 1; k < MAX_HOLD; k++) begin
            tick();
            checkOutput("to_hold", 32'(grant), 32'h4);
            checkOutput("to_nopulse", 32'(timeout), 32'h0);
        end
        tick();
        checkOutput("to_release", 32'(grant), 32'h0);
        checkOutput("to_pulse", 32'(timeout), 32'h1);
        tick();
        checkOutput("to_pulse_end", 32'(timeout), 32'h0);
        repeat (4) begin
            tick();
            checkOutput("to_blocked", 32'(grant), 32'h0);
        end
        req = 4'b0000;
        tick();
        req = 4'b0100;
        tick();
        checkOutput("to_regrant", 32'(grant), 32'h4);
        req = 4'b0000;
        repeat (3) tick();

        // Reset in the middle of a hold.
        applyStimulus(1'b1, 1'b0, 32'h0, 4'b0001, 16'h000A);
        tick();
        checkOutput("mid_grant", 32'(grant), 32'h1);
        tick();
        checkOutput("mid_field", 32'(value[3:0]), 32'hA);
        reset_n = 1'b0;
        tick();
        checkOutput("mid_rst_value", value, 32'h0);
        checkOutput("mid_rst_grant", 32'(grant), 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 4'b0011, 16'h00BA);
        tick();
        checkOutput("mid_ptr_restart", 32'(grant), 32'h1);
        req = 4'b0000;
        repeat (3) tick();

        // Background write and grant entry on the same edge.
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF5, 4'b0001, 16'h0009);
        tick();
        checkOutput("sim_bg", value, 32'hFFFF_FFF5);
        tick();
        checkOutput("sim_owner", value, 32'hFFFF_FFF9);
        applyStimulus(1'b1, 1'b0, 32'h0, 4'b0000, 16'h0000);
        repeat (3) tick();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            req_data = 16'($urandom);
            bg_valid = 1'($urandom_range(0, 1));
            bg_data  = $urandom;
            reset_n  = ($urandom_range(0, 63) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/override_arbiter.md
# override_arbiter

Owns a WIDTH-bit register whose FIELD_W-bit field can be overridden by any of NREQ requesters, in the manner of a procedural assign/deassign pair. A background writer updates the register on the clock. While an override is granted, the field tracks the owner's data and background writes to the field are blocked. On release, the field keeps the last override value until the next background write. It sits between the test-sequencing logic and the shared status/value register.

## Interface
- NREQ, 4: number of override requesters (2..8)
- WIDTH, 32: register width
- FIELD_LSB, 0: LSB of the overridable field
- FIELD_W, 4: overridable field width; FIELD_LSB+FIELD_W <= WIDTH
- MAX_HOLD, 0: maximum grant length in cycles; 0 disables the timeout

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- bg_valid  in  1  background write strobe
- bg_data  in  WIDTH  background write data
- req  in  NREQ  override request, one bit per requester, level-held
- req_data  in  NREQ*FIELD_W  override data; requester i uses bits [i*FIELD_W +: FIELD_W]
- grant  out  NREQ  one-hot grant (all zero when idle)
- override_active  out  1  an override currently owns the field
- timeout  out  1  one-cycle pulse when MAX_HOLD forces a release
- value  out  WIDTH  the register

## Operation
- States:
  - IDLE: no owner.
  - HOLD: one owner.
  - GAP: one mandatory idle cycle after any release.
- IDLE, any req bit set → HOLD. The owner is the first set bit found by a round-robin scan starting at ptr, upward with wrap from NREQ-1 to 0.
- HOLD → GAP when either:
  - the owner's req is 0 (voluntary release), or
  - MAX_HOLD≠0 and hold_cnt reaches MAX_HOLD-1 (forced release; timeout pulses).
- GAP → IDLE unconditionally.
- ptr = (owner+1) mod NREQ, updated on entry to HOLD. A forced-release owner is marked blocked. It is ineligible for arbitration until its req is seen low for at least one cycle.
- hold_cnt clears on entry to HOLD and increments each HOLD cycle. It saturates at MAX_HOLD-1 and its width covers MAX_HOLD.
- Register update per clock:
  - Bits outside the field: take bg_data when bg_valid=1, otherwise hold.
  - Field bits in HOLD: take the owner's req_data, regardless of bg_valid.
  - Field bits in IDLE/GAP: take bg_data when bg_valid=1, otherwise hold. After release, the last override value persists until the first bg_valid.
- Requests from non-owners during HOLD/GAP are not queued. They are re-evaluated on the next IDLE.
- Changes to req_data of a non-owner have no effect.

## Timing
- Reset (reset_n=0 at an edge) sets:
  - value=0, grant=0, override_active=0, timeout=0
  - state=IDLE, ptr=0, hold_cnt=0, blocked=0
- Reset takes priority over all other updates, including mid-HOLD. The grant drops at that edge and the field goes to 0.
- Grant latency: req sampled high at edge N in IDLE → grant and override_active high after edge N. The field takes the owner's data at edge N+1. grant=1 only in HOLD; override_active equals (state==HOLD).
- Field tracking: the owner's req_data at edge k appears in value after edge k, while HOLD is still active at edge k.
- Release: owner's req low at edge R → grant=0 after R. The field is not written at R (the last HOLD write was at R-1). GAP lasts R..R+1; the earliest new grant is after edge R+2.
- Timeout with MAX_HOLD=M: grant is high for exactly M cycles, and timeout is high in the cycle after the last grant cycle.
- bg_valid in the same cycle as grant entry: the field takes bg_data at that edge, since the owner takes effect from the next edge. Bits outside the field always take bg_data.

## Test plan
- Background only: reset, then bg_valid with bg_data=0x0000_0003 every cycle → value=0x3. No grants; override_active=0.
- Override and release:
  - req[1]=1 with data 0x2 → grant=4'b0010 one cycle later, then value[3:0]=0x2 while bg_valid keeps writing 0x3.
  - Drop req[1] with bg_valid=0 → value holds 0x2.
  - Then bg_valid with 0x3 → value=0x3.
- Round-robin: req=4'b1011 held, with each owner releasing after 2 cycles → grant order 0,1,3,0. Exactly one GAP cycle between grants.
- Timeout with MAX_HOLD=5:
  - req[2] held → grant high 5 cycles, then timeout pulse.
  - req[2] stays blocked while held high, even though it is the only request.
  - After req[2] is dropped one cycle and reasserted → it is granted again.
- Reset mid-HOLD: reset_n=0 while grant=4'b0001 and the field is 0xA → after the edge, value=0, grant=0, ptr=0. The next request is arbitrated from requester 0.
- Simultaneous: in IDLE, bg_valid with 0xFFFF_FFF5 and req[0] with 0x9 at the same edge → value=0xFFFF_FFF5, then 0xFFFF_FFF9 at the next edge.
